// File: rtl/register_arb_pkg.sv
// Shared types, default sizes and the round-robin search helper for the
// register arbiter slice.
package register_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int MAX_REQ            = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Walks offsets from the highest down so the smallest offset from ptr
  // (the highest-priority candidate) is the last one written.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         ptr,
                                       input int                 n);
    rr_pick_t   r;
    int         pos;
    logic [2:0] k;
    r = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        pos = (int'(ptr) + i) % n;
        k   = pos[2:0];
        if (req[k]) begin
          r.found = 1'b1;
          r.idx   = k;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/register_arbiter_rr_priority.sv
// Combinational rotate-and-first-set search: returns the first requester at
// or after ptr (wrapping) and whether any requester was found.
module rr_priority
  import register_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  rr_pick_t pick;

  always_comb begin
    pick = rr_pick(MAX_REQ'(req), 3'(ptr), NUM_REQ);
  end

  assign idx   = IDX_W'(pick.idx);
  assign valid = pick.found;

endmodule

// File: rtl/register_arbiter.sv
// Round-robin arbiter sharing one register among NUM_REQ requesters; all
// register-side outputs and the ownership report are registered.
module register_arbiter
  import register_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int NUM_REQ    = DEFAULT_NUM_REQ,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          ra_reset,
  input  logic [NUM_REQ-1:0]            ra_req,
  input  logic [NUM_REQ-1:0]            ra_clr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ra_data,
  output logic [NUM_REQ-1:0]            ra_gnt,
  output logic [DATA_WIDTH-1:0]         reg_in,
  output logic                          reg_wr,
  output logic                          reg_reset,
  output logic [IDX_W-1:0]              ra_owner,
  output logic                          ra_owner_valid
);

  arb_state_t            state_reg;
  logic [IDX_W-1:0]      ptr_reg;
  logic [NUM_REQ-1:0]    gnt_reg;
  logic [DATA_WIDTH-1:0] reg_in_reg;
  logic                  reg_wr_reg;
  logic                  reg_reset_reg;
  logic [IDX_W-1:0]      owner_reg;
  logic                  owner_valid_reg;

  logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];
  logic [NUM_REQ-1:0]    cand;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic [IDX_W-1:0]      ptr_next;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign data_slice[gi] = ra_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // The requester just granted is still lowering its request this edge.
  assign cand = (state_reg == GRANT) ? (ra_req & ~gnt_reg) : ra_req;

  rr_priority #(.NUM_REQ(NUM_REQ)) u_rr_priority (
    .req   (cand),
    .ptr   (ptr_reg),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign ptr_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  always_ff @(posedge clock or posedge ra_reset) begin
    if (ra_reset) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      gnt_reg         <= '0;
      reg_in_reg      <= '0;
      reg_wr_reg      <= 1'b0;
      reg_reset_reg   <= 1'b0;
      owner_reg       <= '0;
      owner_valid_reg <= 1'b0;
    end else if (pick_valid) begin
      state_reg       <= GRANT;
      ptr_reg         <= ptr_next;
      gnt_reg         <= NUM_REQ'(1) << pick_idx;
      reg_in_reg      <= ra_clr[pick_idx] ? '0 : data_slice[pick_idx];
      reg_wr_reg      <= ~ra_clr[pick_idx];
      reg_reset_reg   <= ra_clr[pick_idx];
      owner_reg       <= pick_idx;
      owner_valid_reg <= 1'b1;
    end else begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      reg_in_reg    <= '0;
      reg_wr_reg    <= 1'b0;
      reg_reset_reg <= 1'b0;
    end
  end

  assign ra_gnt         = gnt_reg;
  assign reg_in         = reg_in_reg;
  assign reg_wr         = reg_wr_reg;
  assign reg_reset      = reg_reset_reg;
  assign ra_owner       = owner_reg;
  assign ra_owner_valid = owner_valid_reg;

endmodule

// File: tb/tb_register_arbiter.sv
// Randomized and directed bench for register_arbiter with a behavioural
// register stand-in and a round-robin reference model.
module tb_register_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic            clock = 1'b0;
  logic            ra_reset;
  logic [NR-1:0]   ra_req;
  logic [NR-1:0]   ra_clr;
  logic [NR*DW-1:0] ra_data;
  logic [NR-1:0]   ra_gnt;
  logic [DW-1:0]   reg_in;
  logic            reg_wr;
  logic            reg_reset;
  logic [1:0]      ra_owner;
  logic            ra_owner_valid;
  logic [DW-1:0]   reg_out = '0;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int            m_ptr;
  int            m_prev_w;
  logic [NR-1:0] exp_gnt;
  logic [DW-1:0] exp_in;
  logic          exp_wr;
  logic          exp_rst;
  logic [1:0]    exp_owner;
  logic          exp_valid;

  always #5 clock = ~clock;

  register_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clock          (clock),
    .ra_reset       (ra_reset),
    .ra_req         (ra_req),
    .ra_clr         (ra_clr),
    .ra_data        (ra_data),
    .ra_gnt         (ra_gnt),
    .reg_in         (reg_in),
    .reg_wr         (reg_wr),
    .reg_reset      (reg_reset),
    .ra_owner       (ra_owner),
    .ra_owner_valid (ra_owner_valid)
  );

  // stand-in for the shared register instance
  always @(posedge clock) begin
    if (reg_reset)   reg_out <= '0;
    else if (reg_wr) reg_out <= reg_in;
  end

  task automatic model_reset();
    m_ptr = 0; m_prev_w = -1;
    exp_gnt = '0; exp_in = '0; exp_wr = 0; exp_rst = 0;
    exp_owner = '0; exp_valid = 0;
  endtask

  // Predict the outputs after the coming edge from the current inputs.
  task automatic model_edge();
    int w;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (m_ptr + k) % NR;
      if (w < 0 && ra_req[j] && j != m_prev_w) w = j;
    end
    exp_gnt = '0; exp_in = '0; exp_wr = 0; exp_rst = 0;
    if (w >= 0) begin
      exp_gnt[w] = 1'b1;
      if (ra_clr[w]) exp_rst = 1'b1;
      else begin
        exp_wr = 1'b1;
        exp_in = ra_data[w*DW +: DW];
      end
      exp_owner = 2'(w);
      exp_valid = 1'b1;
      m_ptr = (w + 1) % NR;
    end
    m_prev_w = w;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic drop_granted();
    ra_req = ra_req & ~ra_gnt;
  endtask

  task automatic do_reset();
    ra_reset = 1'b1;
    model_reset();
    @(negedge clock);
    ra_reset = 1'b0;
  endtask

  task automatic test_reset();
    ra_req = '0; ra_clr = '0; ra_data = '0;
    ra_reset = 1'b1;
    model_reset();
    #2;
    n_checks++;
    if ({ra_gnt, reg_in, reg_wr, reg_reset, ra_owner, ra_owner_valid} !== '0)
      $display("FAIL reset_outputs: got gnt=%b in=%h wr=%b rst=%b own=%0d v=%b, want all 0",
               ra_gnt, reg_in, reg_wr, reg_reset, ra_owner, ra_owner_valid);
    else n_pass++;
    @(negedge clock);
    ra_reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (ra_gnt !== 4'b0000 || reg_wr !== 1'b0 || ra_owner_valid !== 1'b0)
        $display("FAIL reset_idle_%0d: gnt=%b wr=%b v=%b, want 0000 0 0", c, ra_gnt, reg_wr, ra_owner_valid);
      else n_pass++;
    end
  endtask

  task automatic test_single_write();
    ra_req = 4'b0100; ra_clr = '0; ra_data = '0;
    ra_data[2*DW +: DW] = 8'hA5;
    step();
    n_checks++;
    if (ra_gnt !== 4'b0100 || reg_wr !== 1'b1 || reg_reset !== 1'b0 || reg_in !== 8'hA5)
      $display("FAIL single_grant: gnt=%b wr=%b rst=%b in=%h, want 0100 1 0 a5", ra_gnt, reg_wr, reg_reset, reg_in);
    else n_pass++;
    n_checks++;
    if (ra_owner !== 2'd2 || ra_owner_valid !== 1'b1)
      $display("FAIL single_owner: own=%0d v=%b, want 2 1", ra_owner, ra_owner_valid);
    else n_pass++;
    drop_granted();
    step();
    n_checks++;
    if (ra_gnt !== 4'b0000 || reg_wr !== 1'b0 || reg_out !== 8'hA5)
      $display("FAIL single_after: gnt=%b wr=%b reg_out=%h, want 0000 0 a5", ra_gnt, reg_wr, reg_out);
    else n_pass++;
    $display("single write: owner=%0d reg_out=%h", ra_owner, reg_out);
  endtask

  task automatic test_all_four();
    do_reset();
    ra_req = 4'b1111; ra_clr = '0;
    for (int i = 0; i < NR; i++) ra_data[i*DW +: DW] = 8'(8'h10 + i);
    for (int k = 0; k < NR; k++) begin
      step();
      n_checks++;
      if (ra_gnt !== (4'b0001 << k) || reg_in !== 8'(8'h10 + k) || ra_gnt !== exp_gnt)
        $display("FAIL all4_grant_%0d: gnt=%b in=%h, want %b %h", k, ra_gnt, reg_in, 4'b0001 << k, 8'(8'h10 + k));
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (reg_out !== 8'(8'h10 + k - 1))
          $display("FAIL all4_regout_%0d: got %h want %h", k, reg_out, 8'(8'h10 + k - 1));
        else n_pass++;
      end
      drop_granted();
    end
    step();
    n_checks++;
    if (ra_gnt !== 4'b0000 || reg_out !== 8'h13)
      $display("FAIL all4_idle: gnt=%b reg_out=%h, want 0000 13", ra_gnt, reg_out);
    else n_pass++;
  endtask

  task automatic test_wrap();
    // put ptr at 3 by granting requester 2 alone
    ra_req = 4'b0100; ra_clr = '0;
    step(); drop_granted(); step();
    ra_req = 4'b1001;
    step();
    n_checks++;
    if (ra_gnt !== 4'b1000 || ra_owner !== 2'd3)
      $display("FAIL wrap_first: gnt=%b own=%0d, want 1000 3", ra_gnt, ra_owner);
    else n_pass++;
    drop_granted();
    step();
    n_checks++;
    if (ra_gnt !== 4'b0001 || ra_owner !== 2'd0)
      $display("FAIL wrap_second: gnt=%b own=%0d, want 0001 0", ra_gnt, ra_owner);
    else n_pass++;
    drop_granted();
    step();
  endtask

  task automatic test_clear();
    ra_req = 4'b0001; ra_clr = '0; ra_data[0 +: DW] = 8'h5A;
    step(); drop_granted(); step();
    n_checks++;
    if (reg_out !== 8'h5A)
      $display("FAIL clear_setup: reg_out=%h want 5a", reg_out);
    else n_pass++;
    ra_req = 4'b0010; ra_clr = 4'b0010; ra_data[DW +: DW] = 8'hEE;
    step();
    n_checks++;
    if (reg_reset !== 1'b1 || reg_wr !== 1'b0 || reg_in !== 8'h00 || ra_gnt !== 4'b0010 || ra_owner !== 2'd1)
      $display("FAIL clear_grant: rst=%b wr=%b in=%h gnt=%b own=%0d, want 1 0 00 0010 1",
               reg_reset, reg_wr, reg_in, ra_gnt, ra_owner);
    else n_pass++;
    drop_granted();
    ra_clr = '0;
    step();
    n_checks++;
    if (reg_out !== 8'h00 || reg_reset !== 1'b0)
      $display("FAIL clear_after: reg_out=%h rst=%b, want 00 0", reg_out, reg_reset);
    else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    ra_req = 4'b0001; ra_clr = '0; ra_data[0 +: DW] = 8'hFF;
    step();
    n_checks++;
    if (reg_wr !== 1'b1 || ra_gnt !== 4'b0001)
      $display("FAIL abort_setup: wr=%b gnt=%b, want 1 0001", reg_wr, ra_gnt);
    else n_pass++;
    drop_granted();
    #2;
    ra_reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (reg_wr !== 1'b0 || ra_gnt !== 4'b0000 || ra_owner_valid !== 1'b0 || ra_owner !== 2'd0)
      $display("FAIL abort_async: wr=%b gnt=%b v=%b own=%0d, want 0 0000 0 0",
               reg_wr, ra_gnt, ra_owner_valid, ra_owner);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if (reg_out === 8'hFF)
      $display("FAIL abort_regout: reg_out=%h, want not ff", reg_out);
    else n_pass++;
    @(negedge clock);
    ra_reset = 1'b0;
    // pointer back at 0: requester 0 beats requester 1
    ra_req = 4'b0011; ra_data[DW +: DW] = 8'h77;
    step();
    n_checks++;
    if (ra_gnt !== 4'b0001 || ra_gnt !== exp_gnt)
      $display("FAIL abort_ptr: gnt=%b, want 0001", ra_gnt);
    else n_pass++;
    drop_granted();
    step(); drop_granted(); step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!ra_req[i] && $urandom_range(0, 2) == 0) begin
          ra_req[i] = 1'b1;
          ra_clr[i] = ($urandom_range(0, 3) == 0);
          ra_data[i*DW +: DW] = 8'($urandom);
        end else if (!ra_req[i]) begin
          ra_clr[i] = $urandom_range(0, 1) == 1;
        end
      end
      step();
      n_checks++;
      if (ra_gnt !== exp_gnt || reg_in !== exp_in || reg_wr !== exp_wr || reg_reset !== exp_rst ||
          ra_owner !== exp_owner || ra_owner_valid !== exp_valid)
        $display("FAIL random_%0d: gnt=%b in=%h wr=%b rst=%b own=%0d v=%b, want %b %h %b %b %0d %b",
                 c, ra_gnt, reg_in, reg_wr, reg_reset, ra_owner, ra_owner_valid,
                 exp_gnt, exp_in, exp_wr, exp_rst, exp_owner, exp_valid);
      else n_pass++;
      drop_granted();
    end
    ra_req = '0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_all_four();
    test_wrap();
    test_clear();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
